// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the instruction fetch sequencer and its queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FLUSH
    } fetch_state_e;

    localparam int INSN_W  = 32;
    localparam int PC_STEP = 4;

    // The scheduler can retire at most two per cycle; an encoding of 3 means two.
    function automatic logic [1:0] clamp_consume(input logic [1:0] cnt);
        return (cnt == 2'd3) ? 2'd2 : cnt;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Single-port, one-outstanding-request instruction memory bus.
interface fetch_sequencer_if;
    import fetch_pkg::*;

    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_busy;
    logic              mem_valid;
    logic [INSN_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_busy,
        input  mem_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_busy,
        output mem_valid,
        output mem_rdata
    );

endinterface

// File: rtl/insn_queue.sv
// Circular instruction buffer: one write port, head and head+1 read ports,
// pop of 0/1/2 per cycle and a synchronous clear that wins over write and pop.
module insn_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [INSN_W-1:0] wr_data,
    input  logic [1:0]        pop,
    output logic [INSN_W-1:0] rd0,
    output logic [INSN_W-1:0] rd1,
    output logic [CW-1:0]     count
);

    logic [INSN_W-1:0] mem_array [DEPTH];
    logic [PW-1:0]     head_reg;
    logic [PW-1:0]     tail_reg;
    logic [CW-1:0]     count_reg;
    logic [PW-1:0]     head_plus1;

    // Storage carries no reset; stale contents are masked by the count.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem_array[tail_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (wr_en) begin
                tail_reg <= tail_reg + PW'(1);
            end
            head_reg  <= head_reg + PW'(pop);
            count_reg <= count_reg + CW'(wr_en) - CW'(pop);
        end
    end

    // Reads are asynchronous so a word written at an edge is visible the next cycle.
    assign head_plus1 = head_reg + PW'(1);
    assign rd0        = mem_array[head_reg];
    assign rd1        = mem_array[head_plus1];
    assign count      = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns fetch PC and head PC, keeps the instruction queue filled from memory and
// presents the two oldest instructions to the dual-issue scheduler.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic [1:0]          consume_cnt,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    fetch_sequencer_if.master   mem_bus,
    output logic [INSN_W-1:0]   instruction0,
    output logic [INSN_W-1:0]   instruction1,
    output logic                valid0,
    output logic                valid1,
    output logic [31:0]         pc0,
    output logic                nothing_filled
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_reg, state_next;
    logic [31:0]       fetch_pc_reg, fetch_pc_next;
    logic [31:0]       pc0_reg, pc0_next;
    logic [CW-1:0]     count;
    logic [INSN_W-1:0] rd0, rd1;
    logic              mem_accept;
    logic              wr_en;
    logic [1:0]        consume_c;
    logic [1:0]        deq;
    logic [31:0]       redirect_aligned;

    assign redirect_aligned = redirect_pc & ~32'd3;

    // Request depends only on registered state and count, never on inputs.
    assign mem_bus.mem_req  = (state_reg == S_REQ) && (count < CW'(DEPTH));
    assign mem_bus.mem_addr = fetch_pc_reg;
    assign mem_accept       = mem_bus.mem_req && !mem_bus.mem_busy;

    always_comb begin
        consume_c = clamp_consume(consume_cnt);
        deq       = 2'd0;
        if (!freeze) begin
            if (count == CW'(0)) begin
                deq = 2'd0;
            end else if (count == CW'(1)) begin
                deq = (consume_c != 2'd0) ? 2'd1 : 2'd0;
            end else begin
                deq = consume_c;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        case (state_reg)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (mem_accept) begin
                    state_next = redirect ? S_FLUSH : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_bus.mem_valid) begin
                    state_next = S_REQ;
                    wr_en      = !redirect;
                end else if (redirect) begin
                    state_next = S_FLUSH;
                end
            end
            // The in-flight response belongs to an abandoned path; drop it.
            S_FLUSH: begin
                if (mem_bus.mem_valid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        pc0_next      = pc0_reg + (32'(deq) << 2);
        if (redirect) begin
            fetch_pc_next = redirect_aligned;
            pc0_next      = redirect_aligned;
        end else if (wr_en) begin
            fetch_pc_next = fetch_pc_reg + 32'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            fetch_pc_reg <= RESET_PC;
            pc0_reg      <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            pc0_reg      <= pc0_next;
        end
    end

    insn_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .clear   (redirect),
        .wr_en   (wr_en),
        .wr_data (mem_bus.mem_rdata),
        .pop     (deq),
        .rd0     (rd0),
        .rd1     (rd1),
        .count   (count)
    );

    assign valid0         = (count != CW'(0));
    assign valid1         = (count >= CW'(2));
    assign nothing_filled = (count == CW'(0));
    assign instruction0   = valid0 ? rd0 : '0;
    assign instruction1   = valid1 ? rd1 : '0;
    assign pc0            = pc0_reg;

endmodule
